// File: rtl/gc_sched_pkg.sv
// ============================================================================
// gc_sched_pkg : shared types and truth-table constants for gc_gate_scheduler
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package gc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] LOGIC_XOR  = 4'b0110;
    localparam logic [3:0] LOGIC_XNOR = 4'b1001;
    localparam logic [3:0] LOGIC_AND  = 4'b1000;

    // Linear gates are garbled for free and consume no table slot.
    function automatic logic is_free_logic(input logic [3:0] lg);
        return (lg == LOGIC_XOR) || (lg == LOGIC_XNOR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gc_gate_scheduler.sv
// ============================================================================
// gc_gate_scheduler : walks netlist ROM gate IDs and issues one gate per cycle
//                     to the garbling engine over valid/ready.
// Build option      : FREE_XOR_EN - mark XOR/XNOR gates free (no table slot)
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module gc_gate_scheduler
    import gc_sched_pkg::*;
#(
    parameter int S = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [S-1:0] num_gates,
    output logic         busy,
    output logic         done,
    output logic [S-1:0] nl_gid,
    input  logic [S-1:0] nl_in0,
    input  logic [S-1:0] nl_in1,
    input  logic         nl_in0F,
    input  logic         nl_in1F,
    input  logic [3:0]   nl_g_logic,
    output logic         g_valid,
    input  logic         g_ready,
    output logic [S-1:0] g_gid,
    output logic [S-1:0] g_in0,
    output logic [S-1:0] g_in1,
    output logic         g_in0F,
    output logic         g_in1F,
    output logic [3:0]   g_logic,
    output logic         g_free,
    output logic [S-1:0] table_idx,
    output logic [S-1:0] tables_total
);

    localparam logic [S-1:0] c_one  = {{(S-1){1'b0}}, 1'b1};
    localparam logic [S-1:0] c_zero = '0;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [S-1:0] r_num;
    logic [S-1:0] r_gid_cnt;
    logic [S-1:0] r_table_cnt;
    logic         r_done;
    logic         r_valid;
    logic [S-1:0] r_gid;
    logic [S-1:0] r_in0;
    logic [S-1:0] r_in1;
    logic         r_in0F;
    logic         r_in1F;
    logic [3:0]   r_logic;
    logic         r_free;
    logic [S-1:0] r_table_idx;

    logic         w_start_acc;
    logic         w_hs;
    logic         w_load;
    logic         w_last_load;
    logic         w_table_inc;
    logic [S-1:0] w_table_nxt;
    logic         w_rom_free;

`ifdef FREE_XOR_EN
    assign w_rom_free = is_free_logic(nl_g_logic);
`else
    assign w_rom_free = 1'b0;
`endif

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_hs        = r_valid && g_ready;
    assign w_load      = (r_state == RUN) && (!r_valid || g_ready);
    assign w_last_load = w_load && (r_gid_cnt == (r_num - c_one));
    assign w_table_inc = w_hs && !r_free;
    // A gate loaded on the same edge its predecessor handshakes must see the bumped count.
    assign w_table_nxt = w_table_inc ? (r_table_cnt + c_one) : r_table_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && (num_gates != c_zero)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last_load) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state == RUN) || (r_state == DRAIN);
        nl_gid = (r_state == RUN) ? r_gid_cnt : c_zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num       <= '0;
            r_gid_cnt   <= '0;
            r_table_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (w_start_acc && (num_gates == c_zero))
                   || ((r_state == DRAIN) && w_hs);
            if (w_start_acc) begin
                r_num       <= num_gates;
                r_gid_cnt   <= '0;
                r_table_cnt <= '0;
            end else begin
                if (w_load) begin
                    r_gid_cnt <= r_gid_cnt + c_one;
                end
                r_table_cnt <= w_table_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_gid       <= '0;
            r_in0       <= '0;
            r_in1       <= '0;
            r_in0F      <= 1'b0;
            r_in1F      <= 1'b0;
            r_logic     <= '0;
            r_free      <= 1'b0;
            r_table_idx <= '0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_gid       <= r_gid_cnt;
            r_in0       <= nl_in0;
            r_in1       <= nl_in1;
            r_in0F      <= nl_in0F;
            r_in1F      <= nl_in1F;
            r_logic     <= nl_g_logic;
            r_free      <= w_rom_free;
            r_table_idx <= w_table_nxt;
        end else if (w_hs) begin
            r_valid <= 1'b0;
        end
    end

    assign done         = r_done;
    assign g_valid      = r_valid;
    assign g_gid        = r_gid;
    assign g_in0        = r_in0;
    assign g_in1        = r_in1;
    assign g_in0F       = r_in0F;
    assign g_in1F       = r_in1F;
    assign g_logic      = r_logic;
    assign g_free       = r_free;
    assign table_idx    = r_table_idx;
    assign tables_total = r_table_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gc_gate_scheduler.sv
// ============================================================================
// tb_gc_gate_scheduler : directed + randomized checks of gc_gate_scheduler
// Revision             : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gc_gate_scheduler;

    localparam int S = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [S-1:0] num_gates = '0;
    logic         busy, done;
    logic [S-1:0] nl_gid;
    logic [S-1:0] nl_in0, nl_in1;
    logic         nl_in0F, nl_in1F;
    logic [3:0]   nl_g_logic;
    logic         g_valid;
    logic         g_ready = 1'b0;
    logic [S-1:0] g_gid, g_in0, g_in1;
    logic         g_in0F, g_in1F;
    logic [3:0]   g_logic;
    logic         g_free;
    logic [S-1:0] table_idx, tables_total;

    logic [S-1:0] rom_in0   [64];
    logic [S-1:0] rom_in1   [64];
    logic         rom_f0    [64];
    logic         rom_f1    [64];
    logic [3:0]   rom_logic [64];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign nl_in0     = (nl_gid < 64) ? rom_in0[nl_gid[5:0]]   : '0;
    assign nl_in1     = (nl_gid < 64) ? rom_in1[nl_gid[5:0]]   : '0;
    assign nl_in0F    = (nl_gid < 64) ? rom_f0[nl_gid[5:0]]    : 1'b0;
    assign nl_in1F    = (nl_gid < 64) ? rom_f1[nl_gid[5:0]]    : 1'b0;
    assign nl_g_logic = (nl_gid < 64) ? rom_logic[nl_gid[5:0]] : 4'd0;

    gc_gate_scheduler #(.S(S)) dut (
        .clk(clk), .rst(rst), .start(start), .num_gates(num_gates),
        .busy(busy), .done(done), .nl_gid(nl_gid),
        .nl_in0(nl_in0), .nl_in1(nl_in1), .nl_in0F(nl_in0F), .nl_in1F(nl_in1F),
        .nl_g_logic(nl_g_logic), .g_valid(g_valid), .g_ready(g_ready),
        .g_gid(g_gid), .g_in0(g_in0), .g_in1(g_in1), .g_in0F(g_in0F),
        .g_in1F(g_in1F), .g_logic(g_logic), .g_free(g_free),
        .table_idx(table_idx), .tables_total(tables_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_free(input int k);
`ifdef FREE_XOR_EN
        return (rom_logic[k] == 4'b0110) || (rom_logic[k] == 4'b1001);
`else
        return 1'b0;
`endif
    endfunction

    // Table slot of gate k = number of table-consuming gates before it.
    function automatic int slots_before(input int k);
        int c = 0;
        for (int j = 0; j < k; j++) if (!exp_free(j)) c++;
        return c;
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_valid"}, 32'(g_valid), 0);
        chk({pfx, "_busy"},  32'(busy), 0);
        chk({pfx, "_done"},  32'(done), 0);
        chk({pfx, "_nlgid"}, 32'(nl_gid), 0);
        chk({pfx, "_gid"},   32'(g_gid), 0);
        chk({pfx, "_in0"},   32'(g_in0), 0);
        chk({pfx, "_logic"}, 32'(g_logic), 0);
        chk({pfx, "_free"},  32'(g_free), 0);
        chk({pfx, "_tidx"},  32'(table_idx), 0);
        chk({pfx, "_ttot"},  32'(tables_total), 0);
    endtask

    task automatic fill_rom(input bit randomize_all);
        for (int i = 0; i < 64; i++) begin
            rom_in0[i] = S'($urandom);
            rom_in1[i] = S'($urandom);
            rom_f0[i]  = 1'($urandom);
            rom_f1[i]  = 1'($urandom);
            if (randomize_all) begin
                case ($urandom_range(0, 3))
                    0:       rom_logic[i] = 4'b0110;
                    1:       rom_logic[i] = 4'b1001;
                    default: rom_logic[i] = 4'($urandom);
                endcase
            end else begin
                rom_logic[i] = 4'b1000;
            end
        end
    endtask

    // Transaction-level model: gates 0..n-1 stream in order; gate 0 appears two
    // cycles after start, each later gate the cycle after its predecessor's
    // handshake, done the cycle after the last handshake.
    task automatic run_pass(input int n, input bit rnd_ready, input int stall_gate,
                            input int stall_len, input int restart_cyc,
                            input int abort_gate, output int done_cyc);
        int  idx = 0;
        bit  vld = 0, dn = 0, bsy = 1, rdy;
        int  tabs = 0;
        int  stall_rem = stall_len;
        int  exp_nl;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1; num_gates = S'(n); g_ready = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start     = (cyc == restart_cyc);
            num_gates = (cyc == restart_cyc) ? S'(9) : S'($urandom_range(0, 31));
            exp_nl = (bsy && !(vld && idx == n - 1) && vld) ? idx + 1 : 0;
            chk("valid", 32'(g_valid), 32'(vld));
            chk("busy",  32'(busy), 32'(bsy));
            chk("done",  32'(done), 32'(dn));
            chk("nl_gid", 32'(nl_gid), exp_nl);
            chk("tables_total", 32'(tables_total), tabs);
            if (vld) begin
                chk("g_gid",   32'(g_gid), idx);
                chk("g_in0",   32'(g_in0), 32'(rom_in0[idx]));
                chk("g_in1",   32'(g_in1), 32'(rom_in1[idx]));
                chk("g_in0F",  32'(g_in0F), 32'(rom_f0[idx]));
                chk("g_in1F",  32'(g_in1F), 32'(rom_f1[idx]));
                chk("g_logic", 32'(g_logic), 32'(rom_logic[idx]));
                chk("g_free",  32'(g_free), 32'(exp_free(idx)));
                if (!exp_free(idx)) chk("table_idx", 32'(table_idx), slots_before(idx));
            end
            if (dn) begin
                done_cyc = cyc;
                break;
            end
            if (vld && idx == abort_gate) begin
                rst = 1'b1;
                #1;
                chk_all_zero("abort");
                @(negedge clk);
                chk("abort_done_hold", 32'(done), 0);
                rst = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk("abort_done_after", 32'(done), 0);
                chk("abort_busy_after", 32'(busy), 0);
                return;
            end
            if (vld && idx == stall_gate && stall_rem > 0) begin
                rdy = 1'b0;
                stall_rem--;
            end else begin
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            g_ready = rdy;
            dn = 1'b0;
            if (vld && rdy) begin
                if (!exp_free(idx)) tabs++;
                if (idx == n - 1) begin
                    vld = 1'b0; bsy = 1'b0; dn = 1'b1;
                end else begin
                    idx++;
                end
            end else if (!vld) begin
                vld = 1'b1;
            end
        end
        chk("pass_completed", 32'(done_cyc >= 0), 1);
        start = 1'b0;
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_ttot", 32'(tables_total), tabs);
    endtask

    initial begin
        int dc0, dc1, dc2, dcx;

        fill_rom(1'b0);
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // zero-gate pass
        start = 1'b1; num_gates = '0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_valid", 32'(g_valid), 0);
        @(negedge clk);
        chk("zero_done_clr", 32'(done), 0);
        chk("zero_valid2", 32'(g_valid), 0);

        // AND, XOR, AND, XNOR with ready held high
        rom_logic[0] = 4'b1000; rom_logic[1] = 4'b0110;
        rom_logic[2] = 4'b1000; rom_logic[3] = 4'b1001;
        run_pass(4, 1'b0, -1, 0, -1, -1, dc0);
        chk("four_done_cycle", dc0, 6);
`ifdef FREE_XOR_EN
        chk("four_tables_total", 32'(tables_total), 2);
`else
        chk("four_tables_total", 32'(tables_total), 4);
`endif

        // stall gate 1 for three cycles
        run_pass(3, 1'b0, -1, 0, -1, -1, dc1);
        run_pass(3, 1'b0, 1, 3, -1, -1, dc2);
        chk("stall_extra_cycles", dc2 - dc1, 3);

        // start pulse mid-pass must be ignored
        run_pass(5, 1'b0, -1, 0, 3, -1, dcx);
        chk("restart_ignored_cycle", dcx, 7);

        // reset while gate 2 of 6 is valid, then restart cleanly
        run_pass(6, 1'b0, -1, 0, -1, 2, dcx);
        run_pass(6, 1'b0, -1, 0, -1, -1, dcx);
        chk("after_abort_cycle", dcx, 8);

        // randomized ROM contents and backpressure
        fill_rom(1'b1);
        for (int p = 0; p < 6; p++) begin
            run_pass($urandom_range(1, 40), 1'b1, -1, 0, $urandom_range(2, 10), -1, dcx);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
